tmds_io_clocking: RTL and testbench

TMDS_IO_CLOCKING -- requirements
Module: tmds_io_clocking

---
 rtl/tmds_io_clocking.sv | 94 +++++++++
 tb/tb_tmds_io_clocking.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_io_clocking.sv
// TMDS I/O clocking: divided word clock, load strobe, synchronized lock
// qualification and an LSB-first parallel-to-serial shifter with a differential output pair.
module tmds_io_clocking #(
    parameter int unsigned DIVIDE       = 5,
    parameter int unsigned LOCK_STROBES = 4
) (
    input  logic              i_clk_io,
    input  logic              i_reset_n,
    input  logic              i_pll_locked,
    input  logic [DIVIDE-1:0] i_data_in,
    output logic              o_clk_div,
    output logic              o_serdes_strobe,
    output logic              o_lock,
    output logic              o_serdes_reset,
    output logic              o_ser_p,
    output logic              o_ser_n
);
    localparam int unsigned     CW       = (DIVIDE > 2) ? $clog2(DIVIDE) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DIVIDE - 1);
    localparam logic [CW-1:0]   CNT_HALF = CW'((DIVIDE + 1) / 2);
    localparam logic [7:0]      LOCK_MAX = 8'(LOCK_STROBES);

    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_next;
    logic              r_clk_div;
    logic              r_strobe;
    logic [1:0]        r_sync;
    logic              w_locked_s;
    logic [7:0]        r_lock_cnt;
    logic              w_lock;
    logic              w_shift_clr;
    logic [DIVIDE-1:0] r_shift;

    always_comb begin
        w_cnt_next = (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
    end

    // clk_div and strobe are registered from the next count so they describe the current phase
    always_ff @(posedge i_clk_io or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt     <= '0;
            r_clk_div <= 1'b1;
            r_strobe  <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_clk_div <= (w_cnt_next < CNT_HALF);
            r_strobe  <= (w_cnt_next == CNT_LAST);
        end
    end

    always_ff @(posedge i_clk_io or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], i_pll_locked};
        end
    end

    assign w_locked_s = r_sync[1];

    always_ff @(posedge i_clk_io or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_lock_cnt <= '0;
        end else if (!w_locked_s) begin
            r_lock_cnt <= '0;
        end else if (r_strobe && (r_lock_cnt != LOCK_MAX)) begin
            r_lock_cnt <= r_lock_cnt + 8'd1;
        end
    end

    assign w_lock = (r_lock_cnt == LOCK_MAX);

    // Clearing on a low locked_s as well makes the shifter drop on the same edge as lock
    assign w_shift_clr = !w_lock || !w_locked_s;

    always_ff @(posedge i_clk_io or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_shift <= '0;
        end else if (w_shift_clr) begin
            r_shift <= '0;
        end else if (r_strobe) begin
            r_shift <= i_data_in;
        end else begin
            r_shift <= {1'b0, r_shift[DIVIDE-1:1]};
        end
    end

    assign o_clk_div       = r_clk_div;
    assign o_serdes_strobe = r_strobe;
    assign o_lock          = w_lock;
    assign o_serdes_reset  = ~w_lock;
    assign o_ser_p         = r_shift[0];
    assign o_ser_n         = ~r_shift[0];
endmodule

// File: tb/tb_tmds_io_clocking.sv
// Bench for tmds_io_clocking: vector tables, corner-case sequences and a
// randomized run compared against an edge-counting reference model.
module tb_tmds_io_clocking;
    localparam int D    = 5;
    localparam int L    = 4;
    localparam int HALF = (D + 1) / 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pll = 1'b0;
    logic [D-1:0] din = '0;
    logic         clk_div, strobe, lock, serdes_reset, ser_p, ser_n;

    int checks = 0;
    int failures = 0;

    tmds_io_clocking #(.DIVIDE(D), .LOCK_STROBES(L)) dut (
        .i_clk_io        (clk),
        .i_reset_n       (rst_n),
        .i_pll_locked    (pll),
        .i_data_in       (din),
        .o_clk_div       (clk_div),
        .o_serdes_strobe (strobe),
        .o_lock          (lock),
        .o_serdes_reset  (serdes_reset),
        .o_ser_p         (ser_p),
        .o_ser_n         (ser_n)
    );

    always #5 clk = ~clk;

    // Reference model: edges since reset release, pll history, strobe run, last load/clear
    int           e;
    int           hist[$];
    int           run;
    bit           m_lock;
    int           last_load;
    int           last_clear;
    logic [D-1:0] word;

    function automatic void model_reset();
        e = 0;
        hist.delete();
        run = 0;
        m_lock = 1'b0;
        last_load = 0;
        last_clear = 0;
        word = '0;
    endfunction

    function automatic void model_edge(input bit p, input logic [D-1:0] d);
        bit ls, stb, lock_prev, clr;
        e++;
        hist.push_back(int'(p));
        ls = (e >= 3) ? (hist[e-3] != 0) : 1'b0;
        stb = ((e - 1) % D) == (D - 1);
        lock_prev = m_lock;
        if (!ls) run = 0;
        else if (stb && run < L) run++;
        m_lock = (run == L);
        clr = !(lock_prev && ls);
        if (clr) last_clear = e;
        else if (stb) begin
            last_load = e;
            word = d;
        end
    endfunction

    function automatic bit exp_ser();
        if (last_load > 0 && last_load > last_clear && (e - last_load) < D)
            return word[e-last_load];
        return 1'b0;
    endfunction

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, e);
        end
    endfunction

    function automatic void check_all(input string tag);
        chk({tag, "_clk_div"}, int'(clk_div), int'((e % D) < HALF));
        chk({tag, "_strobe"}, int'(strobe), int'((e % D) == D - 1));
        chk({tag, "_lock"}, int'(lock), int'(m_lock));
        chk({tag, "_serdes_reset"}, int'(serdes_reset), int'(!m_lock));
        chk({tag, "_ser_p"}, int'(ser_p), int'(exp_ser()));
        chk({tag, "_ser_n"}, int'(ser_n), int'(!exp_ser()));
    endfunction

    task automatic tick();
        bit p;
        logic [D-1:0] d;
        p = pll;
        d = din;
        @(posedge clk);
        #1;
        model_edge(p, d);
        check_all("model");
    endtask

    task automatic wait_strobe();
        int n = 0;
        while (!strobe && n < 2 * D) begin
            tick();
            n++;
        end
        chk("strobe_seen", int'(strobe), 1);
    endtask

    task automatic wait_lock(input int bound);
        int n = 0;
        while (!lock && n < bound) begin
            tick();
            n++;
        end
        chk("lock_reached", int'(lock), 1);
    endtask

    typedef struct {
        bit           pll;
        logic [D-1:0] din;
        bit           clk_div;
        bit           strobe;
        bit           lock;
        bit           ser_p;
    } vec_t;

    vec_t tbl[10];

    task automatic run_table(input string tag);
        for (int i = 0; i < 10; i++) begin
            pll = tbl[i].pll;
            din = tbl[i].din;
            tick();
            chk({tag, "_clk_div"}, int'(clk_div), int'(tbl[i].clk_div));
            chk({tag, "_strobe"}, int'(strobe), int'(tbl[i].strobe));
            chk({tag, "_lock"}, int'(lock), int'(tbl[i].lock));
            chk({tag, "_ser_p"}, int'(ser_p), int'(tbl[i].ser_p));
            chk({tag, "_ser_n"}, int'(ser_n), int'(!tbl[i].ser_p));
        end
    endtask

    bit exp28[5];

    initial begin
        tbl[0] = '{1'b0, 5'h1F, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 5'h15, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 5'h0A, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 5'h1F, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 5'h01, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 5'h10, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 5'h1F, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 5'h03, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 5'h1F, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 5'h0C, 1'b1, 1'b0, 1'b0, 1'b0};
        exp28 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset state, then unlocked free-running pattern
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_table("unlocked");

        // Lock acquisition with pll_locked high from release: 4th strobe is edge 20
        rst_n = 1'b0;
        model_reset();
        pll = 1'b1;
        din = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 19; i++) tick();
        chk("lock_before_4th_strobe", int'(lock), 0);
        tick();
        chk("lock_at_4th_strobe", int'(lock), 1);
        chk("serdes_reset_at_lock", int'(serdes_reset), 0);

        // Single word LSB first
        wait_strobe();
        din = 5'b10110;
        tick();
        din = 5'($urandom);
        chk("w10110_bit0", int'(ser_p), int'(exp28[0]));
        for (int i = 1; i < D; i++) begin
            tick();
            chk("w10110_bit", int'(ser_p), int'(exp28[i]));
            chk("w10110_n", int'(ser_n), int'(!exp28[i]));
        end

        // Back-to-back words without gap
        wait_strobe();
        din = 5'b11111;
        tick();
        chk("w11111_bit0", int'(ser_p), 1);
        din = 5'b00001;
        for (int i = 1; i < D; i++) begin
            tick();
            chk("w11111_bit", int'(ser_p), 1);
        end
        tick();
        chk("w00001_bit0", int'(ser_p), 1);
        din = '0;
        for (int i = 1; i < D; i++) begin
            tick();
            chk("w00001_bit", int'(ser_p), 0);
        end

        // Loss of lock mid-word, then relock
        wait_strobe();
        din = 5'b11111;
        tick();
        tick();
        pll = 1'b0;
        tick();
        chk("loss_edge1_lock", int'(lock), 1);
        tick();
        chk("loss_edge2_lock", int'(lock), 1);
        tick();
        chk("loss_edge3_lock", int'(lock), 0);
        chk("loss_edge3_ser_p", int'(ser_p), 0);
        chk("loss_edge3_ser_n", int'(ser_n), 1);
        pll = 1'b1;
        wait_lock(2 + (L + 1) * D + 2);

        // Randomized data and lock drops against the model
        for (int i = 0; i < 800; i++) begin
            din = 5'($urandom);
            if (pll && $urandom_range(0, 59) == 0) pll = 1'b0;
            else if (!pll && $urandom_range(0, 9) == 0) pll = 1'b1;
            tick();
        end

        // Asynchronous reset mid-word
        pll = 1'b1;
        wait_lock(2 + (L + 1) * D + 2);
        wait_strobe();
        din = 5'b11011;
        tick();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_clk_div", int'(clk_div), 1);
        chk("async_strobe", int'(strobe), 0);
        chk("async_lock", int'(lock), 0);
        chk("async_serdes_reset", int'(serdes_reset), 1);
        chk("async_ser_p", int'(ser_p), 0);
        chk("async_ser_n", int'(ser_n), 1);
        pll = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all("in_reset");
        rst_n = 1'b1;
        run_table("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
